// File: rtl/e203_dma_icb_arb_if.sv
// ICB command/response bundle shared by the core, the DMA engine and the slave port.
// The master modport drives commands and consumes responses; slave is the mirror.
interface e203_dma_icb_arb_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [AW-1:0]     cmd_addr;
  logic              cmd_read;
  logic [DW-1:0]     cmd_wdata;
  logic [DW/8-1:0]   cmd_wmask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_err;
  logic [DW-1:0]     rsp_rdata;

  modport master (
    output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/e203_dma_icb_arb.sv
// Two-master ICB arbiter (core m0, DMA m1) onto one slave with round-robin grant,
// grant lock on stalled commands and an in-order ID FIFO steering responses.
module e203_dma_icb_arb #(
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32,
  parameter int unsigned OSTD = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  e203_dma_icb_arb_if.slave      m0,
  e203_dma_icb_arb_if.slave      m1,
  e203_dma_icb_arb_if.master     s,
  output logic [$clog2(OSTD):0]  ostd_cnt,
  output logic                   arb_err
);

  localparam int unsigned PW = $clog2(OSTD);
  localparam int unsigned CW = PW + 1;

  logic              lock_q;
  logic              lock_id_q;
  logic              rr_last_q;
  logic [OSTD-1:0]   fifo_q;
  logic [PW-1:0]     wptr_q;
  logic [PW-1:0]     rptr_q;

  logic              gnt_any;
  logic              gnt_id;
  logic              gnt_valid;
  logic [AW-1:0]     gnt_addr;
  logic              gnt_read;
  logic [DW-1:0]     gnt_wdata;
  logic [DW/8-1:0]   gnt_wmask;
  logic              full;
  logic              empty;
  logic              cmd_hsk;
  logic              rsp_hsk;
  logic              head;

  // Grant: a stalled command keeps its master; otherwise round-robin on ties.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = 1'b0;
    if (lock_q) begin
      gnt_any = 1'b1;
      gnt_id  = lock_id_q;
    end else if (m0.cmd_valid && m1.cmd_valid) begin
      gnt_any = 1'b1;
      gnt_id  = ~rr_last_q;
    end else if (m0.cmd_valid) begin
      gnt_any = 1'b1;
      gnt_id  = 1'b0;
    end else if (m1.cmd_valid) begin
      gnt_any = 1'b1;
      gnt_id  = 1'b1;
    end
  end

  always_comb begin
    gnt_valid = m0.cmd_valid;
    gnt_addr  = m0.cmd_addr;
    gnt_read  = m0.cmd_read;
    gnt_wdata = m0.cmd_wdata;
    gnt_wmask = m0.cmd_wmask;
    if (gnt_id) begin
      gnt_valid = m1.cmd_valid;
      gnt_addr  = m1.cmd_addr;
      gnt_read  = m1.cmd_read;
      gnt_wdata = m1.cmd_wdata;
      gnt_wmask = m1.cmd_wmask;
    end
  end

  assign full  = (ostd_cnt == CW'(OSTD));
  assign empty = (ostd_cnt == '0);

  assign s.cmd_valid = ~rst & gnt_any & gnt_valid & ~full;
  assign s.cmd_addr  = gnt_addr;
  assign s.cmd_read  = gnt_read;
  assign s.cmd_wdata = gnt_wdata;
  assign s.cmd_wmask = gnt_wmask;

  assign m0.cmd_ready = ~rst & gnt_any & ~gnt_id & s.cmd_ready & ~full;
  assign m1.cmd_ready = ~rst & gnt_any &  gnt_id & s.cmd_ready & ~full;

  assign cmd_hsk = s.cmd_valid & s.cmd_ready;

  // Responses follow the oldest outstanding ID; with nothing outstanding they are swallowed.
  assign head        = fifo_q[rptr_q];
  assign s.rsp_ready = empty | (head ? m1.rsp_ready : m0.rsp_ready);
  assign m0.rsp_valid = s.rsp_valid & ~empty & ~head;
  assign m1.rsp_valid = s.rsp_valid & ~empty &  head;
  assign m0.rsp_err   = s.rsp_err;
  assign m1.rsp_err   = s.rsp_err;
  assign m0.rsp_rdata = s.rsp_rdata;
  assign m1.rsp_rdata = s.rsp_rdata;

  assign rsp_hsk = s.rsp_valid & s.rsp_ready & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      rr_last_q <= 1'b1;
      fifo_q    <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      ostd_cnt  <= '0;
      arb_err   <= 1'b0;
    end else begin
      lock_q    <= s.cmd_valid & ~s.cmd_ready;
      lock_id_q <= gnt_id;
      if (cmd_hsk) begin
        rr_last_q      <= gnt_id;
        fifo_q[wptr_q] <= gnt_id;
        wptr_q         <= wptr_q + PW'(1);
      end
      if (rsp_hsk) begin
        rptr_q <= rptr_q + PW'(1);
      end
      ostd_cnt <= ostd_cnt + CW'(cmd_hsk) - CW'(rsp_hsk);
      if (s.rsp_valid && empty) begin
        arb_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_e203_dma_icb_arb.sv
// Scoreboard bench for e203_dma_icb_arb: directed traffic from two masters into a
// simple in-order slave model; a negedge monitor checks every command and response.
module tb_e203_dma_icb_arb;

  logic       clk;
  logic       rst;
  logic [2:0] ostd_cnt;
  logic       arb_err;

  e203_dma_icb_arb_if #(.AW(32), .DW(32)) m0_bus ();
  e203_dma_icb_arb_if #(.AW(32), .DW(32)) m1_bus ();
  e203_dma_icb_arb_if #(.AW(32), .DW(32)) s_bus ();

  e203_dma_icb_arb #(.AW(32), .DW(32), .OSTD(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .m0       (m0_bus.slave),
    .m1       (m1_bus.slave),
    .s        (s_bus.master),
    .ostd_cnt (ostd_cnt),
    .arb_err  (arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic id; logic [31:0] addr; } cmd_t;
  typedef struct packed { logic id; logic [31:0] rdata; logic err; } rsp_t;

  cmd_t exp_cmd[$];
  rsp_t exp_rsp[$];

  int checks = 0;
  int errors = 0;

  // master stimulus state
  logic [31:0] m0_list[8];
  logic [31:0] m1_list[8];
  int          m0_n = 0, m0_i = 0, m1_n = 0, m1_i = 0;
  bit          m0_en = 0, m1_en = 0;

  // slave model state: accepted addresses answered in order, rdata = ~addr, err = addr[2]
  logic [31:0] pend[16];
  logic [3:0]  ph = '0, pt = '0;
  logic [4:0]  pn = '0;
  bit          rsp_en = 0;
  bit          orphan = 0;

  // handshakes captured by the monitor, consumed on the next edge
  bit          m0_acc = 0, m1_acc = 0, cmd_hsk_f = 0, slv_pop_f = 0;
  logic [31:0] cap_addr = '0;

  assign s_bus.rsp_valid = orphan | (rsp_en & (pn != 5'd0));
  assign s_bus.rsp_rdata = ~pend[ph];
  assign s_bus.rsp_err   = pend[ph][2];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void push_cmd(input logic id, input logic [31:0] a);
    cmd_t c;
    c.id = id; c.addr = a;
    exp_cmd.push_back(c);
  endfunction

  function automatic void push_exp(input logic id, input logic [31:0] a);
    rsp_t r;
    push_cmd(id, a);
    r.id = id; r.rdata = ~a; r.err = a[2];
    exp_rsp.push_back(r);
  endfunction

  function automatic void rsp_check(input logic id, input logic [31:0] rdata, input logic err);
    rsp_t r;
    if (exp_rsp.size() == 0) begin
      checks++; errors++;
      $display("FAIL rsp_unexpected: got id %0d rdata %h expected no response", id, rdata);
    end else begin
      r = exp_rsp.pop_front();
      chk("rsp_id",    32'(id),  32'(r.id));
      chk("rsp_rdata", rdata,    r.rdata);
      chk("rsp_err",   32'(err), 32'(r.err));
    end
  endfunction

  // Monitor: sampled mid-cycle, so each valid&ready seen here completes at the next posedge.
  always @(negedge clk) begin
    cmd_t c;
    m0_acc    = m0_bus.cmd_valid & m0_bus.cmd_ready;
    m1_acc    = m1_bus.cmd_valid & m1_bus.cmd_ready;
    cmd_hsk_f = s_bus.cmd_valid & s_bus.cmd_ready;
    cap_addr  = s_bus.cmd_addr;
    slv_pop_f = s_bus.rsp_valid & s_bus.rsp_ready & ~orphan;
    if (cmd_hsk_f) begin
      if (exp_cmd.size() == 0) begin
        checks++; errors++;
        $display("FAIL cmd_unexpected: got addr %h expected no command", s_bus.cmd_addr);
      end else begin
        c = exp_cmd.pop_front();
        chk("cmd_id",     32'(m1_acc), 32'(c.id));
        chk("cmd_single", 32'(m0_acc ^ m1_acc), 32'd1);
        chk("cmd_addr",   s_bus.cmd_addr, c.addr);
        chk("cmd_read",   32'(s_bus.cmd_read), 32'(c.addr[4]));
        chk("cmd_wdata",  s_bus.cmd_wdata, c.addr ^ 32'h5A5A_5A5A);
        chk("cmd_wmask",  32'(s_bus.cmd_wmask), 32'(c.addr[7:4]));
      end
    end
    if (m0_bus.rsp_valid || m1_bus.rsp_valid)
      chk("rsp_onehot", 32'(m0_bus.rsp_valid & m1_bus.rsp_valid), 32'd0);
    if (m0_bus.rsp_valid && m0_bus.rsp_ready) rsp_check(1'b0, m0_bus.rsp_rdata, m0_bus.rsp_err);
    if (m1_bus.rsp_valid && m1_bus.rsp_ready) rsp_check(1'b1, m1_bus.rsp_rdata, m1_bus.rsp_err);
  end

  task automatic drive();
    logic [31:0] a;
    a = m0_list[m0_i[2:0]];
    m0_bus.cmd_valid = m0_en && (m0_i < m0_n);
    m0_bus.cmd_addr  = a;
    m0_bus.cmd_read  = a[4];
    m0_bus.cmd_wdata = a ^ 32'h5A5A_5A5A;
    m0_bus.cmd_wmask = a[7:4];
    a = m1_list[m1_i[2:0]];
    m1_bus.cmd_valid = m1_en && (m1_i < m1_n);
    m1_bus.cmd_addr  = a;
    m1_bus.cmd_read  = a[4];
    m1_bus.cmd_wdata = a ^ 32'h5A5A_5A5A;
    m1_bus.cmd_wmask = a[7:4];
  endtask

  // Advance one cycle: apply completed handshakes to masters and slave, then redrive.
  task automatic tick();
    @(posedge clk);
    #1;
    if (m0_acc) m0_i++;
    if (m1_acc) m1_i++;
    if (cmd_hsk_f) begin
      pend[pt] = cap_addr;
      pt = pt + 4'd1;
      pn = pn + 5'd1;
    end
    if (slv_pop_f) begin
      ph = ph + 4'd1;
      pn = pn - 5'd1;
    end
    m0_acc = 0; m1_acc = 0; cmd_hsk_f = 0; slv_pop_f = 0;
    drive();
    #1;
  endtask

  task automatic wait_cnt(input int n, input int lim);
    int k = 0;
    while (ostd_cnt != 3'(n) && k < lim) begin tick(); k++; end
    chk("wait_cnt", 32'(ostd_cnt), 32'(n));
  endtask

  task automatic wait_idle(input int lim);
    int k = 0;
    while ((exp_cmd.size() != 0 || exp_rsp.size() != 0 || ostd_cnt != 3'd0) && k < lim) begin
      tick(); k++;
    end
    chk("drain_cmd", 32'(exp_cmd.size()), 32'd0);
    chk("drain_rsp", 32'(exp_rsp.size()), 32'd0);
    chk("drain_cnt", 32'(ostd_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    s_bus.cmd_ready  = 1'b1;
    m0_bus.rsp_ready = 1'b1;
    m1_bus.rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin m0_list[i] = '0; m1_list[i] = '0; end
    for (int i = 0; i < 16; i++) pend[i] = '0;

    // reset state, with m0 already requesting
    m0_list[0] = 32'h0000_0100; m0_n = 1; m0_i = 0; m0_en = 1;
    drive();
    #1;
    chk("rst_cnt",       32'(ostd_cnt), 32'd0);
    chk("rst_err",       32'(arb_err), 32'd0);
    chk("rst_s_valid",   32'(s_bus.cmd_valid), 32'd0);
    chk("rst_m0_ready",  32'(m0_bus.cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(m0_bus.rsp_valid | m1_bus.rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_valid_hold", 32'(s_bus.cmd_valid), 32'd0);
    m0_en = 0; drive();
    #2 rst = 1'b0;
    tick();

    // both masters valid every cycle: grants alternate m0, m1, m0, m1
    m0_list[0] = 32'h0000_0100; m0_list[1] = 32'h0000_0104; m0_n = 2; m0_i = 0;
    m1_list[0] = 32'h0000_0200; m1_list[1] = 32'h0000_0204; m1_n = 2; m1_i = 0;
    push_exp(1'b0, 32'h0000_0100);
    push_exp(1'b1, 32'h0000_0200);
    push_exp(1'b0, 32'h0000_0104);
    push_exp(1'b1, 32'h0000_0204);
    rsp_en = 1; m0_en = 1; m1_en = 1;
    drive(); #1;
    chk("rr_first_addr", s_bus.cmd_addr, 32'h0000_0100);
    wait_idle(40);
    m0_en = 0; m1_en = 0; drive();

    // slave stalls m1 for three cycles; m0 joins in the second; grant must stay on m1
    s_bus.cmd_ready = 1'b0;
    m1_list[0] = 32'h0000_0300; m1_n = 1; m1_i = 0;
    m0_list[0] = 32'h0000_0110; m0_n = 1; m0_i = 0;
    push_exp(1'b1, 32'h0000_0300);
    push_exp(1'b0, 32'h0000_0110);
    m1_en = 1; drive(); #1;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin m0_en = 1; drive(); #1; end
      chk("lock_s_valid",  32'(s_bus.cmd_valid), 32'd1);
      chk("lock_addr",     s_bus.cmd_addr, 32'h0000_0300);
      chk("lock_m0_ready", 32'(m0_bus.cmd_ready), 32'd0);
      tick();
    end
    s_bus.cmd_ready = 1'b1; drive(); #1;
    chk("lock_release_addr", s_bus.cmd_addr, 32'h0000_0300);
    chk("lock_m1_ready",     32'(m1_bus.cmd_ready), 32'd1);
    chk("lock_m0_ready_rel", 32'(m0_bus.cmd_ready), 32'd0);
    wait_idle(40);
    m0_en = 0; m1_en = 0; drive();

    // fill to OSTD with no responses, then pop one while m0 is still requesting
    rsp_en = 0;
    m0_list[0] = 32'h0000_0120; m0_list[1] = 32'h0000_0124; m0_list[2] = 32'h0000_0128;
    m0_list[3] = 32'h0000_012C; m0_list[4] = 32'h0000_0130; m0_n = 5; m0_i = 0;
    for (int i = 0; i < 5; i++) push_exp(1'b0, m0_list[i]);
    m0_en = 1; drive(); #1;
    repeat (4) tick();
    chk("full_cnt",      32'(ostd_cnt), 32'd4);
    chk("full_m0_valid", 32'(m0_bus.cmd_valid), 32'd1);
    chk("full_m0_ready", 32'(m0_bus.cmd_ready), 32'd0);
    chk("full_s_valid",  32'(s_bus.cmd_valid), 32'd0);
    tick();
    chk("full_cnt_hold", 32'(ostd_cnt), 32'd4);
    rsp_en = 1; drive(); #1;
    chk("pop_s_rsp_valid", 32'(s_bus.rsp_valid), 32'd1);
    chk("pop_s_rsp_ready", 32'(s_bus.rsp_ready), 32'd1);
    chk("pop_m0_ready",    32'(m0_bus.cmd_ready), 32'd0);
    chk("pop_s_valid",     32'(s_bus.cmd_valid), 32'd0);
    tick();
    rsp_en = 0; drive(); #1;
    chk("after_pop_cnt",      32'(ostd_cnt), 32'd3);
    chk("after_pop_s_valid",  32'(s_bus.cmd_valid), 32'd1);
    chk("after_pop_m0_ready", 32'(m0_bus.cmd_ready), 32'd1);
    tick();
    chk("refill_cnt", 32'(ostd_cnt), 32'd4);
    rsp_en = 1; drive();
    wait_idle(40);
    m0_en = 0; drive();

    // m1 then m0 issued; m1 response held off for 5 cycles blocks the m0 response
    m1_bus.rsp_ready = 1'b0;
    m1_list[0] = 32'h0000_0400; m1_n = 1; m1_i = 0;
    m0_list[0] = 32'h0000_0140; m0_n = 1; m0_i = 0;
    push_exp(1'b1, 32'h0000_0400);
    push_exp(1'b0, 32'h0000_0140);
    m1_en = 1; drive();
    tick();
    m0_en = 1; drive(); #1;
    wait_cnt(2, 10);
    for (int c = 0; c < 5; c++) begin
      chk("order_m1_valid",  32'(m1_bus.rsp_valid), 32'd1);
      chk("order_s_ready",   32'(s_bus.rsp_ready), 32'd0);
      chk("order_m0_valid",  32'(m0_bus.rsp_valid), 32'd0);
      tick();
    end
    m1_bus.rsp_ready = 1'b1;
    wait_idle(40);
    m0_en = 0; m1_en = 0; drive();

    // orphan response with nothing outstanding, then reset clears the sticky flag
    orphan = 1; #1;
    chk("orph_s_ready",  32'(s_bus.rsp_ready), 32'd1);
    chk("orph_m_valid",  32'(m0_bus.rsp_valid | m1_bus.rsp_valid), 32'd0);
    chk("orph_err_pre",  32'(arb_err), 32'd0);
    tick();
    orphan = 0; #1;
    chk("orph_err_set",  32'(arb_err), 32'd1);
    chk("orph_cnt",      32'(ostd_cnt), 32'd0);
    repeat (3) tick();
    chk("orph_err_held", 32'(arb_err), 32'd1);
    rst = 1'b1; #1;
    chk("orph_err_clr",  32'(arb_err), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // reset with two commands outstanding drops them; m0 traffic then resumes
    rsp_en = 0;
    m0_list[0] = 32'h0000_0150; m0_list[1] = 32'h0000_0154; m0_n = 2; m0_i = 0;
    push_cmd(1'b0, 32'h0000_0150);
    push_cmd(1'b0, 32'h0000_0154);
    m0_en = 1; drive(); #1;
    wait_cnt(2, 10);
    m0_en = 0; drive();
    rst = 1'b1; #1;
    chk("arst_cnt",     32'(ostd_cnt), 32'd0);
    chk("arst_s_valid", 32'(s_bus.cmd_valid), 32'd0);
    ph = '0; pt = '0; pn = '0;
    tick();
    rst = 1'b0;
    rsp_en = 1;
    m0_list[0] = 32'h0000_0160; m0_list[1] = 32'h0000_0164; m0_n = 2; m0_i = 0;
    push_exp(1'b0, 32'h0000_0160);
    push_exp(1'b0, 32'h0000_0164);
    m0_en = 1; drive(); #1;
    wait_idle(40);
    chk("post_rst_err", 32'(arb_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
